// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and the RAM handshake state.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/mem_arbiter_pkg.sv
// Types and constants for the instruction/data RAM port arbiter.
package mem_arbiter_pkg;

   import cpu_types_pkg::*;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } arb_state_t;

   // Load value returned to the owner of a failed or timed-out transaction.
   localparam word_t BADLOAD = 32'hBAD1_BAD1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM model.
interface mem_arbiter_if;

   import cpu_types_pkg::*;

   // instruction requester
   logic      iREN;
   word_t     iaddr;
   logic      iwait;
   word_t     iload;

   // data requester
   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   logic      dwait;
   word_t     dload;

   // RAM side
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   // sticky error flag
   logic      memerr;

   modport arb (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
   );

   modport ram (
      input  ramREN, ramWEN, ramaddr, ramstore,
      output ramload, ramstate
   );

   modport tb (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
   );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Grant watchdog: counts grant cycles without completion and flags expiry.
module arb_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0] r_tcnt;

   // Clear while no grant is active; count each grant cycle that did not complete.
   always_ff @(posedge CLK) begin
      if (RST || i_clr) begin
         r_tcnt <= '0;
      end else if (i_en) begin
         r_tcnt <= r_tcnt + TW'(1);
      end
   end

   assign o_expire = (r_tcnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// Data has priority; a bounded streak of data grants forces an instruction
// grant, and a watchdog turns hung transactions into error completions.
module mem_arbiter
   import cpu_types_pkg::*;
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_DSTREAK = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic          CLK,
   input  logic          RST,
   mem_arbiter_if.arb    bus
);

   localparam int SW = $clog2(MAX_DSTREAK + 1);

   arb_state_t    r_state;
   logic [SW-1:0] r_dstreak;
   logic          r_memerr;

   logic w_dreq;
   logic w_ign;
   logic w_dgn;
   logic w_own_req;
   logic w_acc;
   logic w_err;
   logic w_done;
   logic w_expire;
   logic w_streak_full;

   assign w_dreq        = bus.dREN | bus.dWEN;
   assign w_ign         = (r_state == IGNT);
   assign w_dgn         = (r_state == DGNT);
   assign w_own_req     = (w_ign & bus.iREN) | (w_dgn & w_dreq);
   assign w_acc         = w_own_req & (bus.ramstate == ACCESS);
   assign w_err         = w_own_req & ~w_acc & ((bus.ramstate == ERROR) | w_expire);
   assign w_done        = w_acc | w_err;
   assign w_streak_full = (r_dstreak == SW'(MAX_DSTREAK));

   arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .CLK      (CLK),
      .RST      (RST),
      .i_clr    (r_state == IDLE),
      .i_en     ((w_ign | w_dgn) & ~w_done),
      .o_expire (w_expire)
   );

   // Strobes follow the live request so a withdrawn request drops them at once.
   assign bus.ramREN   = (w_ign & bus.iREN) | (w_dgn & bus.dREN & ~bus.dWEN);
   assign bus.ramWEN   = w_dgn & bus.dWEN;
   assign bus.ramaddr  = w_ign ? bus.iaddr : (w_dgn ? bus.daddr : '0);
   assign bus.ramstore = w_dgn ? bus.dstore : '0;

   // Wait drops only in the owner's completion cycle.
   assign bus.iwait = bus.iREN & ~(w_ign & w_done);
   assign bus.dwait = w_dreq & ~(w_dgn & w_done);

   assign bus.iload = (w_ign & w_acc) ? bus.ramload : ((w_ign & w_err) ? BADLOAD : '0);
   assign bus.dload = (w_dgn & w_acc) ? bus.ramload : ((w_dgn & w_err) ? BADLOAD : '0);

   assign bus.memerr = r_memerr;

   // Grant sequencing, data-streak tracking and sticky error capture.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= IDLE;
         r_dstreak <= '0;
         r_memerr  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_dreq && bus.iREN && w_streak_full) begin
                  r_state <= IGNT;
               end else if (w_dreq) begin
                  r_state <= DGNT;
               end else if (bus.iREN) begin
                  r_state <= IGNT;
               end
            end
            IGNT: begin
               if (!bus.iREN) begin
                  r_state <= IDLE;
               end else if (w_done) begin
                  r_state   <= IDLE;
                  r_dstreak <= '0;
                  if (w_err) r_memerr <= 1'b1;
               end
            end
            DGNT: begin
               if (!w_dreq) begin
                  r_state <= IDLE;
               end else if (w_done) begin
                  r_state <= IDLE;
                  if (w_err) r_memerr <= 1'b1;
                  if (!bus.iREN) begin
                     r_dstreak <= '0;
                  end else if (!w_streak_full) begin
                     r_dstreak <= r_dstreak + SW'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table plus hand-written corner sequences.
module tb_mem_arbiter;

   import cpu_types_pkg::*;
   import mem_arbiter_pkg::*;

   logic CLK;
   logic RST;
   int   total;
   int   bad;

   mem_arbiter_if bus();

   mem_arbiter #(
      .MAX_DSTREAK (4),
      .TIMEOUT     (64)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.arb)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      string     name;
      logic      iren, dren, dwen;
      word_t     iaddr, daddr, dstore, ramload;
      ramstate_t rs;
      logic      e_ren, e_wen;
      word_t     e_addr, e_store;
      logic      e_iwait, e_dwait;
      word_t     e_iload, e_dload;
      logic      e_err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input string nm, input logic ir, dr, dw,
                               input word_t ia, da, ds, rl, input ramstate_t rs,
                               input logic er, ew, input word_t ea, es,
                               input logic eiw, edw, input word_t eil, edl,
                               input logic eer);
      vec_t v;
      v.name = nm; v.iren = ir; v.dren = dr; v.dwen = dw;
      v.iaddr = ia; v.daddr = da; v.dstore = ds; v.ramload = rl; v.rs = rs;
      v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es;
      v.e_iwait = eiw; v.e_dwait = edw; v.e_iload = eil; v.e_dload = edl;
      v.e_err = eer;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic chk_str(input string nm, input string act, input string req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%s required=%s", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic ir, dr, dw, input word_t ia, da, ds, rl,
                        input ramstate_t rs);
      bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw;
      bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
      bus.ramload = rl; bus.ramstate = rs;
   endtask

   // Records which requester owns each grant cycle ('D' or 'I' by address)
   // until n grants are seen or the cycle budget runs out.
   task automatic record(input int n, input word_t ia, input int budget, output string seq);
      seq = "";
      for (int c = 0; c < budget; c++) begin
         @(negedge CLK);
         if (bus.ramREN || bus.ramWEN) begin
            seq = {seq, (bus.ramaddr == ia) ? "I" : "D"};
            if (seq.len() == n) break;
         end
      end
   endtask

   initial begin
      string seq;
      total = 0;
      bad   = 0;

      // Cycle table: each row is one clock; state before each row is implied
      // by the rows above it.
      // instruction only
      tbl.push_back(mk("a0",1,0,0,'h40,0,0,0,FREE,           0,0,0,0,1,0,0,0,0));
      tbl.push_back(mk("a1",1,0,0,'h40,0,0,0,BUSY,           1,0,'h40,0,1,0,0,0,0));
      tbl.push_back(mk("a2",1,0,0,'h40,0,0,'h8C010004,ACCESS,1,0,'h40,0,0,0,'h8C010004,0,0));
      tbl.push_back(mk("a3",0,0,0,0,0,0,0,FREE,              0,0,0,0,0,0,0,0,0));
      // simultaneous instruction + data write: data first, bubble, then instruction
      tbl.push_back(mk("b0",1,0,1,'h40,'h100,'hCAFEF00D,0,FREE,          0,0,0,0,1,1,0,0,0));
      tbl.push_back(mk("b1",1,0,1,'h40,'h100,'hCAFEF00D,'h11112222,ACCESS,0,1,'h100,'hCAFEF00D,1,0,0,'h11112222,0));
      tbl.push_back(mk("b2",1,0,0,'h40,'h100,'hCAFEF00D,0,FREE,          0,0,0,0,1,0,0,0,0));
      tbl.push_back(mk("b3",1,0,0,'h40,'h100,'hCAFEF00D,'h33334444,ACCESS,1,0,'h40,0,0,0,'h33334444,0,0));
      tbl.push_back(mk("b4",0,0,0,0,0,0,0,FREE,              0,0,0,0,0,0,0,0,0));
      // read and write both asserted: write wins, live request steers strobe
      tbl.push_back(mk("c0",0,1,1,0,'h200,5,0,FREE,          0,0,0,0,0,1,0,0,0));
      tbl.push_back(mk("c1",0,1,1,0,'h200,5,0,BUSY,          0,1,'h200,5,0,1,0,0,0));
      tbl.push_back(mk("c2",0,1,0,0,'h200,5,0,BUSY,          1,0,'h200,5,0,1,0,0,0));
      tbl.push_back(mk("c3",0,1,0,0,'h200,5,'h77,ACCESS,     1,0,'h200,5,0,0,0,'h77,0));
      tbl.push_back(mk("c4",0,0,0,0,0,0,0,FREE,              0,0,0,0,0,0,0,0,0));
      // instruction abort mid-grant
      tbl.push_back(mk("d0",1,0,0,'h80,0,0,0,FREE,           0,0,0,0,1,0,0,0,0));
      tbl.push_back(mk("d1",1,0,0,'h80,0,0,0,BUSY,           1,0,'h80,0,1,0,0,0,0));
      tbl.push_back(mk("d2",0,0,0,'h80,0,0,0,BUSY,           0,0,'h80,0,0,0,0,0,0));
      tbl.push_back(mk("d3",1,0,0,'h80,0,0,0,FREE,           0,0,0,0,1,0,0,0,0));
      tbl.push_back(mk("d4",1,0,0,'h80,0,0,'hABCD,ACCESS,    1,0,'h80,0,0,0,'hABCD,0,0));
      tbl.push_back(mk("d5",0,0,0,0,0,0,0,FREE,              0,0,0,0,0,0,0,0,0));

      // reset state
      RST = 1'b1;
      drive(0,0,0,0,0,0,0,FREE);
      tick();
      tick();
      drive(1,1,0,'h44,'h300,0,0,FREE);
      @(negedge CLK);
      chk("rst.ramREN", bus.ramREN, 0);
      chk("rst.ramWEN", bus.ramWEN, 0);
      chk("rst.ramaddr", bus.ramaddr, 0);
      chk("rst.iwait", bus.iwait, 1);
      chk("rst.dwait", bus.dwait, 1);
      chk("rst.memerr", bus.memerr, 0);
      tick();
      RST = 1'b0;
      drive(0,0,0,0,0,0,0,FREE);

      foreach (tbl[i]) begin
         tick();
         drive(tbl[i].iren, tbl[i].dren, tbl[i].dwen, tbl[i].iaddr, tbl[i].daddr,
               tbl[i].dstore, tbl[i].ramload, tbl[i].rs);
         @(negedge CLK);
         chk({tbl[i].name, ".ramREN"},   bus.ramREN,   tbl[i].e_ren);
         chk({tbl[i].name, ".ramWEN"},   bus.ramWEN,   tbl[i].e_wen);
         chk({tbl[i].name, ".ramaddr"},  bus.ramaddr,  tbl[i].e_addr);
         chk({tbl[i].name, ".ramstore"}, bus.ramstore, tbl[i].e_store);
         chk({tbl[i].name, ".iwait"},    bus.iwait,    tbl[i].e_iwait);
         chk({tbl[i].name, ".dwait"},    bus.dwait,    tbl[i].e_dwait);
         chk({tbl[i].name, ".iload"},    bus.iload,    tbl[i].e_iload);
         chk({tbl[i].name, ".dload"},    bus.dload,    tbl[i].e_dload);
         chk({tbl[i].name, ".memerr"},   bus.memerr,   tbl[i].e_err);
      end

      // starvation guard: four data grants, one instruction, then data again
      tick();
      drive(1,1,0,'h44,'h300,0,0,ACCESS);
      record(6, 'h44, 40, seq);
      chk_str("starve.seq", seq, "DDDDID");
      tick();
      drive(0,0,0,0,0,0,0,FREE);

      // watchdog timeout on a hung data read
      tick();
      drive(0,1,0,0,'h500,0,0,BUSY);
      @(negedge CLK);
      for (int k = 1; k <= 64; k++) begin
         tick();
         @(negedge CLK);
         if (k < 64) begin
            chk($sformatf("tmo.dwait%0d", k), bus.dwait, 1);
         end else begin
            chk("tmo.dwait64", bus.dwait, 0);
            chk("tmo.dload", bus.dload, 32'hBAD1BAD1);
            chk("tmo.ramREN", bus.ramREN, 1);
            chk("tmo.memerr_pre", bus.memerr, 0);
         end
      end
      tick();
      drive(0,0,0,0,0,0,0,FREE);
      @(negedge CLK);
      chk("tmo.memerr", bus.memerr, 1);
      chk("tmo.idle", bus.ramREN, 0);

      // good instruction transaction leaves memerr sticky
      tick();
      drive(1,0,0,'h60,0,0,'h12345678,ACCESS);
      @(negedge CLK);
      tick();
      @(negedge CLK);
      chk("good.iwait", bus.iwait, 0);
      chk("good.iload", bus.iload, 'h12345678);
      chk("good.memerr", bus.memerr, 1);
      tick();
      drive(0,0,0,0,0,0,0,FREE);
      @(negedge CLK);
      chk("good.memerr2", bus.memerr, 1);

      // RAM-reported error completes the data request with the bad pattern
      tick();
      drive(0,1,0,0,'h600,0,'h55,ERROR);
      @(negedge CLK);
      tick();
      @(negedge CLK);
      chk("err.dwait", bus.dwait, 0);
      chk("err.dload", bus.dload, 32'hBAD1BAD1);
      tick();
      drive(0,0,0,0,0,0,0,FREE);

      // reset mid data grant, after one streak increment
      tick();
      drive(1,1,0,'h44,'h300,0,0,ACCESS);
      @(negedge CLK);
      tick();
      @(negedge CLK);
      chk("rmid.dgnt1", bus.dwait, 0);
      tick();
      bus.ramstate = BUSY;
      @(negedge CLK);
      tick();
      RST = 1'b1;
      @(negedge CLK);
      chk("rmid.inflight", bus.ramREN, 1);
      tick();
      RST = 1'b0;
      bus.ramstate = ACCESS;
      @(negedge CLK);
      chk("rmid.ramREN", bus.ramREN, 0);
      chk("rmid.ramWEN", bus.ramWEN, 0);
      chk("rmid.ramaddr", bus.ramaddr, 0);
      chk("rmid.ramstore", bus.ramstore, 0);
      chk("rmid.iwait", bus.iwait, 1);
      chk("rmid.dwait", bus.dwait, 1);
      chk("rmid.dload", bus.dload, 0);
      chk("rmid.memerr", bus.memerr, 0);
      record(5, 'h44, 40, seq);
      chk_str("rmid.streak", seq, "DDDDI");
      tick();
      drive(0,0,0,0,0,0,0,FREE);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
